// File: rtl/sipo_rx_ctrl.sv
// Serial receive controller: start-bit detect, WIDTH-bit SIPO capture,
// optional even-parity check, stop-bit check and a valid/ready output word.
module sipo_rx_ctrl #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             si,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             busy,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StData   = 2'd1;
  localparam logic [1:0] StParity = 2'd2;
  localparam logic [1:0] StStop   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             perr_q, perr_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             parity_err_q, parity_err_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             consume;

  assign consume = out_valid_q & out_ready;

  // Next-state logic for the frame sequencer and output handshake.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    perr_d       = perr_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q & ~consume;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (!si) begin
          state_d = StData;
          cnt_d   = '0;
          perr_d  = 1'b0;
        end
      end
      StData: begin
        shreg_d = {shreg_q[WIDTH-2:0], si};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d = PARITY_EN ? StParity : StStop;
        end
      end
      StParity: begin
        // Even parity: data bits plus parity bit must XOR to zero.
        perr_d  = (^shreg_q) ^ si;
        state_d = StStop;
      end
      StStop: begin
        state_d = StIdle;
        if (!si) begin
          frame_err_d = 1'b1;
        end else if (perr_q) begin
          parity_err_d = 1'b1;
        end else if (out_valid_q && !out_ready) begin
          // Unconsumed word stays put; the new frame is lost.
          overrun_d = 1'b1;
        end else begin
          out_data_d  = shreg_q;
          out_valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      shreg_q      <= '0;
      cnt_q        <= '0;
      perr_q       <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      perr_q       <= perr_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign busy       = (state_q != StIdle);
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Scoreboard bench for sipo_rx_ctrl (WIDTH=4, PARITY_EN=1).
module tb_sipo_rx_ctrl;

  localparam logic [1:0] EvWord = 2'd0;
  localparam logic [1:0] EvPerr = 2'd1;
  localparam logic [1:0] EvFerr = 2'd2;
  localparam logic [1:0] EvOvr  = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] data;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       si;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_valid;
  logic       busy;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   busy_cnt = 0;
  int   valid_cnt = 0;
  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;

  sipo_rx_ctrl #(
    .WIDTH    (4),
    .PARITY_EN(1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .si        (si),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic expect_ev(input logic [1:0] kind, input logic [3:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Pop one expected event and compare it against an observed one.
  task automatic observe(input logic [1:0] kind, input logic [3:0] data);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d data=%b, expected none", kind, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== kind || (kind == EvWord && e.data !== data)) begin
        errors++;
        $display("FAIL event: got kind=%0d data=%b, expected kind=%0d data=%b",
                 kind, data, e.kind, e.data);
      end
    end
  endtask

  // Monitor: a new word is presented when out_valid rises or is refilled after a consume.
  always @(negedge clk) begin
    if (out_valid && (!prev_valid || prev_ready)) observe(EvWord, out_data);
    if (parity_err) observe(EvPerr, out_data);
    if (frame_err)  observe(EvFerr, out_data);
    if (overrun)    observe(EvOvr, out_data);
    if (busy) busy_cnt++;
    if (out_valid) valid_cnt++;
    prev_valid = out_valid;
    prev_ready = out_ready;
  end

  task automatic send_bit(input logic b);
    si = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [3:0] data, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 3; i >= 0; i--) send_bit(data[i]);
    send_bit(par);
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  initial begin
    rst       = 1'b0;
    si        = 1'b1;
    out_ready = 1'b1;

    // 1: reset hold with si toggling
    send_bit(1'b0);
    send_bit(1'b1);
    check("reset_outputs", {out_data, out_valid, busy, parity_err, frame_err, overrun}, 32'd0);

    // 2: good frame 1011, parity 1
    rst = 1'b1;
    idle(2);
    busy_cnt  = 0;
    valid_cnt = 0;
    expect_ev(EvWord, 4'b1011);
    send_frame(4'b1011, 1'b1, 1'b1);
    idle(3);
    check("good_busy_cycles", busy_cnt, 6);
    check("good_valid_cycles", valid_cnt, 1);
    check("good_data_held", out_data, 4'b1011);

    // 3: parity error
    expect_ev(EvPerr, 4'b0000);
    send_frame(4'b1011, 1'b0, 1'b1);
    idle(2);
    check("perr_valid_low", out_valid, 1'b0);
    check("perr_data_kept", out_data, 4'b1011);

    // 4: framing error, then immediate restart on si=0
    expect_ev(EvFerr, 4'b0000);
    send_frame(4'b0110, 1'b0, 1'b0);
    expect_ev(EvWord, 4'b0001);
    send_frame(4'b0001, 1'b1, 1'b1);
    idle(2);
    check("ferr_recover_data", out_data, 4'b0001);

    // 5: overrun with out_ready held low
    out_ready = 1'b0;
    expect_ev(EvWord, 4'b1100);
    send_frame(4'b1100, 1'b0, 1'b1);
    idle(1);
    expect_ev(EvOvr, 4'b0000);
    send_frame(4'b0011, 1'b0, 1'b1);
    check("ovr_data_kept", out_data, 4'b1100);
    check("ovr_valid_held", out_valid, 1'b1);
    idle(1);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    check("ovr_consumed", out_valid, 1'b0);

    // 6: reset mid-frame, then a clean frame
    out_ready = 1'b1;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    rst = 1'b0;
    send_bit(1'b1);
    rst = 1'b1;
    check("midreset_busy", busy, 1'b0);
    check("midreset_data", out_data, 4'b0000);
    idle(1);
    expect_ev(EvWord, 4'b0101);
    send_frame(4'b0101, 1'b0, 1'b1);
    idle(3);
    check("midreset_new_data", out_data, 4'b0101);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
